// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
// The rx pin is synchronised through two flops. A start bit is confirmed
// half a bit after the falling edge, and the data and stop bits are then
// sampled once per bit period. Each good byte goes into a one-entry holding
// register that is drained through a valid/ready handshake. A low stop bit
// raises frame_err. A byte that completes while the holding register is
// still full raises overrun and is dropped.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    // Terminal counts for the 9-bit bit-period counter.
    localparam logic [8:0] CNT_BIT_LAST  = 9'(CLKS_PER_BIT - 1);
    localparam logic [8:0] CNT_HALF_LAST = 9'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Two-flop synchroniser. Only rx_sync_q is used past this point.
    logic       rx_meta_q;
    logic       rx_sync_q;

    // Frame FSM state.
    state_t     state_q,   state_d;
    logic [8:0] cnt_q,     cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q,   shreg_d;

    // Holding register and the registered status pulses.
    logic [7:0] data_q,      data_d;
    logic       valid_q,     valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q,   overrun_d;

    // Goes high for one cycle when a stop bit is sampled high.
    logic       deliver_s;

    // Bring the asynchronous rx pin into the clk domain. Reset to idle-high
    // so that reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame sequencing: start qualification, data shifting, stop check and
    // break recovery.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        deliver_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d   = 9'd0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = 9'd0;
                    if (!rx_sync_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went high again before mid-start: treat it as a glitch.
                        state_d   = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    cnt_d   = 9'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = 9'd0;
                    if (rx_sync_q) begin
                        // Return at mid-stop so that the next start edge is
                        // caught with half a bit of slack.
                        deliver_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so that it cannot retrigger a frame.
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
                cnt_d = 9'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 9'd0;
            end
        endcase
    end

    // Holding register: accept a byte when the register is empty or is
    // drained in the same cycle. Otherwise drop the byte and flag overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver_s) begin
            if (!valid_q || ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, counters, holding register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 9'd0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomised serial frames for uart_rx. A passive
// monitor logs handshakes and pulse activity. Expected bytes come from a
// queue of the bytes the bench sent.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int NOM = 434;   // nominal clocks per bit at 50 MHz / 115200
    localparam int SLOW = 443;  // +2 %
    localparam int FAST = 425;  // -2 %

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state. Only the monitor writes these signals.
    logic [7:0] hs_log [0:255];
    int   hs_count = 0;
    int   fe_pulses = 0, fe_cycles = 0, ov_pulses = 0, ov_cycles = 0;
    int   busy_cycles = 0, viol = 0, run = 0, last_run = 0;
    int   rise_cyc = 0, ov_cyc = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_fe    <= 1'b0;
            prev_ov    <= 1'b0;
            run        <= 0;
        end else begin
            if (valid && ready) begin
                hs_log[hs_count[7:0]] <= data;
                hs_count <= hs_count + 1;
            end
            if (frame_err) fe_cycles <= fe_cycles + 1;
            if (frame_err && !prev_fe) fe_pulses <= fe_pulses + 1;
            if (overrun) ov_cycles <= ov_cycles + 1;
            if (overrun && !prev_ov) begin
                ov_pulses <= ov_pulses + 1;
                ov_cyc    <= cyc;
            end
            if (busy) busy_cycles <= busy_cycles + 1;
            if (valid && !prev_valid) rise_cyc <= cyc;
            if (valid) run <= run + 1;
            else if (prev_valid) begin
                last_run <= run;
                run      <= 0;
            end
            if (prev_valid && !prev_ready && (!valid || data !== prev_data)) viol <= viol + 1;
            prev_valid <= valid;
            prev_ready <= ready;
            prev_fe    <= frame_err;
            prev_ov    <= overrun;
            prev_data  <= data;
        end
    end

    // Reference model: bytes the bench expects to see handed over, in order.
    logic [7:0] exp_q [$];
    int rd = 0;
    int last_start = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one 8N1 frame with the given bit period. The line is left at
    // the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int period);
        last_start = cyc;
        rx = 1'b0;
        wait_clks(period);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            wait_clks(period);
        end
        rx = stop;
        wait_clks(period);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        check({tag, "_present"}, {31'd0, (hs_count > rd)}, 32'd1);
        check({tag, "_data"}, {24'd0, hs_log[rd[7:0]]}, {24'd0, exp});
        rd++;
    endtask

    task automatic drain_expected(input string tag);
        while (exp_q.size() > 0) begin
            expect_byte(tag, exp_q.pop_front());
        end
        check({tag, "_hs_count"}, 32'(hs_count), 32'(rd));
    endtask

    initial begin
        logic [7:0] hello [7];
        int fe0, fe1, ov0, ov1, bz0, lat, s2;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

        // Reset values
        wait_clks(3);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        wait_clks(10);

        // 1. Single byte 0x55
        ready = 1'b1;
        fe0 = fe_pulses; ov0 = ov_pulses;
        send_frame(8'h55, 1'b1, NOM);
        wait_clks(20);
        lat = rise_cyc - last_start;
        check("t1_latency_4126pm2", {31'd0, (lat >= 4124 && lat <= 4128)}, 32'd1);
        exp_q.push_back(8'h55);
        drain_expected("t1");
        check("t1_valid_run", 32'(last_run), 32'd1);
        check("t1_valid_low", {31'd0, valid}, 32'd0);
        check("t1_no_fe", 32'(fe_pulses - fe0), 32'd0);
        check("t1_no_ov", 32'(ov_pulses - ov0), 32'd0);

        // 2. HELLO\r\n back-to-back, +2 % then -2 %
        fe0 = fe_pulses; ov0 = ov_pulses;
        for (int i = 0; i < 7; i++) begin
            send_frame(hello[i], 1'b1, SLOW);
            exp_q.push_back(hello[i]);
        end
        for (int i = 0; i < 7; i++) begin
            send_frame(hello[i], 1'b1, FAST);
            exp_q.push_back(hello[i]);
        end
        wait_clks(600);
        drain_expected("t2");
        check("t2_no_fe", 32'(fe_pulses - fe0), 32'd0);
        check("t2_no_ov", 32'(ov_pulses - ov0), 32'd0);

        // Randomised bytes, periods within +/-2 % and idle gaps
        fe0 = fe_pulses; ov0 = ov_pulses;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, int'($urandom_range(FAST, SLOW)));
            exp_q.push_back(b);
            wait_clks(int'($urandom_range(0, 40)));
        end
        wait_clks(600);
        drain_expected("rnd");
        check("rnd_no_fe", 32'(fe_pulses - fe0), 32'd0);
        check("rnd_no_ov", 32'(ov_pulses - ov0), 32'd0);

        // 3. Glitch: 100 clk low pulse
        fe0 = fe_pulses; ov0 = ov_pulses; bz0 = busy_cycles;
        rx = 1'b0;
        wait_clks(100);
        rx = 1'b1;
        wait_clks(400);
        check("t3_busy_cycles", 32'(busy_cycles - bz0), 32'd217);
        check("t3_busy_low", {31'd0, busy}, 32'd0);
        check("t3_no_hs", 32'(hs_count), 32'(rd));
        check("t3_no_fe", 32'(fe_pulses - fe0), 32'd0);
        check("t3_no_ov", 32'(ov_pulses - ov0), 32'd0);

        // 4. Framing error with a held-low line, then a good frame
        fe0 = fe_pulses; fe1 = fe_cycles; ov0 = ov_pulses;
        send_frame(8'hA5, 1'b0, NOM);
        wait_clks(NOM);
        check("t4_busy_in_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        check("t4_busy_at_release", {31'd0, busy}, 32'd1);
        wait_clks(4);
        check("t4_busy_after", {31'd0, busy}, 32'd0);
        check("t4_fe_pulses", 32'(fe_pulses - fe0), 32'd1);
        check("t4_fe_width", 32'(fe_cycles - fe1), 32'd1);
        check("t4_no_hs", 32'(hs_count), 32'(rd));
        wait_clks(100);
        send_frame(8'h3C, 1'b1, NOM);
        wait_clks(100);
        exp_q.push_back(8'h3C);
        drain_expected("t4b");
        check("t4_no_ov", 32'(ov_pulses - ov0), 32'd0);

        // 5a. Overrun: ready low, two frames
        ready = 1'b0;
        fe0 = fe_pulses; ov0 = ov_pulses; ov1 = ov_cycles;
        send_frame(8'h11, 1'b1, NOM);
        send_frame(8'h22, 1'b1, NOM);
        s2 = last_start;
        wait_clks(300);
        check("t5_valid_held", {31'd0, valid}, 32'd1);
        check("t5_data_kept", {24'd0, data}, 32'h11);
        check("t5_ov_pulses", 32'(ov_pulses - ov0), 32'd1);
        check("t5_ov_width", 32'(ov_cycles - ov1), 32'd1);
        check("t5_ov_time", 32'(ov_cyc - s2), 32'd4126);
        check("t5_no_hs_yet", 32'(hs_count), 32'(rd));
        ready = 1'b1;
        wait_clks(3);
        ready = 1'b0;
        expect_byte("t5_drain", 8'h11);
        check("t5_valid_fell", {31'd0, valid}, 32'd0);

        // 5b. ready pulsed exactly on the delivery cycle of the second byte
        ov0 = ov_pulses;
        send_frame(8'h11, 1'b1, NOM);
        wait_clks(50);
        fork
            send_frame(8'h22, 1'b1, NOM);
            begin
                wait_clks(4125);
                ready = 1'b1;
                wait_clks(1);
                ready = 1'b0;
            end
        join
        wait_clks(100);
        check("t5b_data", {24'd0, data}, 32'h22);
        check("t5b_valid", {31'd0, valid}, 32'd1);
        check("t5b_no_ov", 32'(ov_pulses - ov0), 32'd0);
        expect_byte("t5b_first", 8'h11);
        ready = 1'b1;
        wait_clks(3);
        ready = 1'b0;
        expect_byte("t5b_second", 8'h22);
        check("t5b_valid_fell", {31'd0, valid}, 32'd0);
        check("t5_no_fe", 32'(fe_pulses - fe0), 32'd0);

        // 6. Reset during data bit 3, then a clean frame
        ready = 1'b1;
        fe0 = fe_pulses; ov0 = ov_pulses;
        rx = 1'b0;
        wait_clks(NOM);
        for (int k = 0; k < 3; k++) begin
            rx = k[0];
            wait_clks(NOM);
        end
        rx = 1'b0;
        wait_clks(100);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        check("t6_rst_data", {24'd0, data}, 32'd0);
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(1000);
        check("t6_no_hs", 32'(hs_count), 32'(rd));
        check("t6_no_fe", 32'(fe_pulses - fe0), 32'd0);
        check("t6_no_ov", 32'(ov_pulses - ov0), 32'd0);
        send_frame(8'h3C, 1'b1, NOM);
        wait_clks(100);
        exp_q.push_back(8'h3C);
        drain_expected("t6b");

        check("valid_hold_rule", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
